// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller
// sitting between a CPU pipeline and a fire-and-forget word memory.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cpu_req/cpu_we           CPU access request and direction (held while stalled)
//   cpu_addr/cpu_wdata       CPU byte address and write word
//   cpu_rdata                read word, valid when cpu_req & ~cpu_we & ~cpu_stall
//   cpu_stall                pipeline hold
//   mem_en/mem_we            one memory request per cycle, write qualifier
//   mem_addr/mem_wdata       memory byte address and write word
//   mem_rdata/mem_valid      returned read word (in order) or write acknowledge
//   hit_cnt/miss_cnt         saturating performance counters
module cache_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8,
  parameter int NUM_SETS  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int OFF_W  = $clog2(BLK_WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - 1 - OFF_W - IDX_W;
  localparam int LINE_W = IDX_W + OFF_W;
  localparam logic [OFF_W:0] CNT_FULL = (OFF_W+1)'(BLK_WORDS);
  localparam logic [OFF_W:0] CNT_LAST = (OFF_W+1)'(BLK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_t                state_q, state_d;
  logic [NUM_SETS-1:0]   valid_q, valid_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [OFF_W:0]        issue_q, issue_d;
  logic [OFF_W:0]        ret_q, ret_d;
  logic                  wr_first_q, wr_first_d;
  logic [15:0]           hit_cnt_q, hit_cnt_d;
  logic [15:0]           miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]      tag_mem_q  [NUM_SETS];
  logic [DATA_W-1:0]     data_mem_q [NUM_SETS*BLK_WORDS];

  logic                  tag_we_s;
  logic                  data_we_s;
  logic [LINE_W-1:0]     data_waddr_s;
  logic [DATA_W-1:0]     data_wval_s;
  logic                  stall_s, mem_en_s, mem_we_s;
  logic [ADDR_W-1:0]     mem_addr_s;
  logic [DATA_W-1:0]     mem_wdata_s;

  logic [OFF_W-1:0]      cpu_off_s;
  logic [IDX_W-1:0]      cpu_idx_s, base_idx_s;
  logic [TAG_W-1:0]      cpu_tag_s, base_tag_s;
  logic                  hit_s;
  logic                  unused_addr_lsb_s;

  assign cpu_off_s  = cpu_addr[OFF_W:1];
  assign cpu_idx_s  = cpu_addr[OFF_W+IDX_W:OFF_W+1];
  assign cpu_tag_s  = cpu_addr[ADDR_W-1:OFF_W+IDX_W+1];
  assign base_idx_s = base_q[OFF_W+IDX_W:OFF_W+1];
  assign base_tag_s = base_q[ADDR_W-1:OFF_W+IDX_W+1];
  // Byte lane bit is meaningless for word accesses.
  assign unused_addr_lsb_s = cpu_addr[0];

  assign hit_s     = valid_q[cpu_idx_s] && (tag_mem_q[cpu_idx_s] == cpu_tag_s);
  assign cpu_rdata = data_mem_q[{cpu_idx_s, cpu_off_s}];

  // Reset forces the handshake outputs quiet even in the reset cycle itself.
  assign cpu_stall = stall_s  & ~rst;
  assign mem_en    = mem_en_s & ~rst;
  assign mem_we    = mem_we_s & ~rst;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // Next-state, storage write enables and memory/CPU handshake outputs.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    base_d       = base_q;
    issue_d      = issue_q;
    ret_d        = ret_q;
    wr_first_d   = wr_first_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    tag_we_s     = 1'b0;
    data_we_s    = 1'b0;
    data_waddr_s = '0;
    data_wval_s  = '0;
    stall_s      = 1'b0;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = '0;
    mem_wdata_s  = '0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            // Every write goes through to memory; hit status only picks the counter.
            stall_s    = 1'b1;
            wr_first_d = 1'b1;
            state_d    = S_WRITE;
            if (hit_s) begin
              hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
              miss_cnt_d = sat_inc(miss_cnt_q);
            end
          end else if (hit_s) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            // Invalidate now so a half-filled block can never hit.
            stall_s             = 1'b1;
            miss_cnt_d          = sat_inc(miss_cnt_q);
            base_d              = {cpu_addr[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
            valid_d[cpu_idx_s]  = 1'b0;
            issue_d             = '0;
            ret_d               = '0;
            state_d             = S_FILL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        stall_s = 1'b1;
        if (issue_q < CNT_FULL) begin
          mem_en_s   = 1'b1;
          mem_addr_s = base_q + ADDR_W'({issue_q[OFF_W-1:0], 1'b0});
          issue_d    = issue_q + 1'b1;
        end else begin
          issue_d = issue_q;
        end
        if (mem_valid && (ret_q < CNT_FULL)) begin
          data_we_s    = 1'b1;
          data_waddr_s = {base_idx_s, ret_q[OFF_W-1:0]};
          data_wval_s  = mem_rdata;
          ret_d        = ret_q + 1'b1;
          if (ret_q == CNT_LAST) begin
            valid_d[base_idx_s] = 1'b1;
            tag_we_s            = 1'b1;
            state_d             = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          ret_d = ret_q;
        end
      end

      S_WRITE: begin
        stall_s     = 1'b1;
        mem_en_s    = wr_first_q;
        mem_we_s    = wr_first_q;
        mem_addr_s  = {cpu_addr[ADDR_W-1:1], 1'b0};
        mem_wdata_s = cpu_wdata;
        wr_first_d  = 1'b0;
        if (mem_valid) begin
          // Release the pipeline in the ack cycle; keep the cached copy coherent.
          stall_s = 1'b0;
          state_d = S_IDLE;
          if (hit_s) begin
            data_we_s    = 1'b1;
            data_waddr_s = {cpu_idx_s, cpu_off_s};
            data_wval_s  = cpu_wdata;
          end else begin
            data_we_s = 1'b0;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, valid bits, fill counters and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      base_q     <= '0;
      issue_q    <= '0;
      ret_q      <= '0;
      wr_first_q <= 1'b0;
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      base_q     <= base_d;
      issue_q    <= issue_d;
      ret_q      <= ret_d;
      wr_first_q <= wr_first_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && tag_we_s) begin
      tag_mem_q[base_idx_s] <= base_tag_s;
    end
    if (!rst && data_we_s) begin
      data_mem_q[data_waddr_s] <= data_wval_s;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] hit_cnt, miss_cnt;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model (set/tag bookkeeping + word memory) ----
  bit          ref_valid [64];
  int          ref_tag   [64];
  logic [15:0] ref_mem   [logic [15:0]];
  int          ref_hits, ref_misses;

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    logic [15:0] w;
    w = a & 16'hFFFE;
    if (ref_mem.exists(w)) return ref_mem[w];
    else return w ^ 16'hA5A5;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 64; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 0;
    end
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  // ---------------- scoreboards ----------------
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } mreq_t;
  mreq_t       exp_mem[$];
  logic [15:0] exp_rd[$];

  // ---------------- memory environment ----------------
  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;
  resp_t       pend[$];
  logic [15:0] sim_mem [logic [15:0]];
  int          cyc = 0;

  function automatic logic [15:0] sim_read(input logic [15:0] a);
    if (sim_mem.exists(a)) return sim_mem[a];
    else return a ^ 16'hA5A5;
  endfunction

  // Drive responses just after each rising edge.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mem_valid = 1'b1;
        mem_rdata = pend[0].data;
        void'(pend.pop_front());
      end else begin
        mem_valid = 1'b0;
      end
    end
  end

  // Memory request monitor: compares every request against the expected traffic.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (exp_mem.size() == 0) begin
        fail_event($sformatf("mem_unexpected we=%b addr=%h", mem_we, mem_addr));
      end else begin
        mreq_t e;
        e = exp_mem.pop_front();
        check("mem_we", 32'(mem_we), 32'(e.we));
        check("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.data));
      end
      if (mem_we === 1'b1) begin
        sim_mem[mem_addr] = mem_wdata;
        pend.push_back(resp_t'{due: cyc + 4, data: 16'h0000});
      end else begin
        pend.push_back(resp_t'{due: cyc + 4, data: sim_read(mem_addr)});
      end
    end
  end

  // Read-data monitor: pops the expected word whenever a read completes.
  always @(negedge clk) begin
    if (rst === 1'b0 && cpu_req === 1'b1 && cpu_we === 1'b0 && cpu_stall === 1'b0) begin
      if (exp_rd.size() == 0) begin
        fail_event($sformatf("rdata_unexpected addr=%h", cpu_addr));
      end else begin
        check($sformatf("rdata@%h", cpu_addr), 32'(cpu_rdata), 32'(exp_rd.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d);
    int  idx, tg, n;
    bit  hit;
    logic [15:0] base;
    idx  = (int'(a) / 16) % 64;
    tg   = int'(a) / 1024;
    hit  = ref_valid[idx] && (ref_tag[idx] == tg);
    base = a & 16'hFFF0;
    if (!we) begin
      if (hit) begin
        ref_hits++;
      end else begin
        ref_misses++;
        ref_hits++;               // the held request hits after the refill
        for (int k = 0; k < 8; k++)
          exp_mem.push_back(mreq_t'{we: 1'b0, addr: base + 16'(2 * k), data: 16'h0000});
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
      end
      exp_rd.push_back(ref_word(a));
    end else begin
      if (hit) ref_hits++;
      else ref_misses++;
      exp_mem.push_back(mreq_t'{we: 1'b1, addr: a & 16'hFFFE, data: d});
      ref_mem[a & 16'hFFFE] = d;
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    @(negedge clk);
    check($sformatf("stall_first@%h", a), 32'(cpu_stall), 32'(we || !hit));
    n = 0;
    while (cpu_stall !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_event($sformatf("timeout waiting stall release @%h", a));
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    check("hit_cnt", 32'(hit_cnt), 32'(ref_hits));
    check("miss_cnt", 32'(miss_cnt), 32'(ref_misses));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", 32'(cpu_stall), 32'd0);
    check("reset_mem_en", 32'(mem_en), 32'd0);
    check("reset_hit_cnt", 32'(hit_cnt), 32'd0);
    check("reset_miss_cnt", 32'(miss_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Directed scenario.
    access(1'b0, 16'h0010, 16'h0000);
    check("first_read_miss_cnt", 32'(miss_cnt), 32'd1);
    check("first_read_hit_cnt", 32'(hit_cnt), 32'd1);
    access(1'b0, 16'h001E, 16'h0000);
    check("second_read_hit_cnt", 32'(hit_cnt), 32'd2);
    access(1'b0, 16'h0410, 16'h0000);
    access(1'b0, 16'h0010, 16'h0000);
    access(1'b1, 16'h0014, 16'h1234);
    access(1'b0, 16'h0014, 16'h0000);
    access(1'b1, 16'h2000, 16'hBEEF);
    access(1'b0, 16'h2000, 16'h0000);

    // Reset in the middle of a fill, after the third returned word.
    for (int k = 0; k < 8; k++)
      exp_mem.push_back(mreq_t'{we: 1'b0, addr: 16'h0030 + 16'(2 * k), data: 16'h0000});
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk);
      if (mem_valid === 1'b1) n++;
    end
    if (n < 3) fail_event("timeout waiting third fill return");
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    exp_mem.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_reset();
    @(negedge clk);
    check("midfill_rst_stall", 32'(cpu_stall), 32'd0);
    check("midfill_rst_mem_en", 32'(mem_en), 32'd0);
    check("midfill_rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("midfill_rst_miss_cnt", 32'(miss_cnt), 32'd0);
    repeat (10) begin
      @(negedge clk);
      check("late_valid_stall", 32'(cpu_stall), 32'd0);
    end
    @(posedge clk);
    #1;
    access(1'b0, 16'h0030, 16'h0000);

    // Randomized traffic over a small address window to mix hits, misses and conflicts.
    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [15:0] a;
      we = ($urandom_range(0, 99) < 30);
      a  = 16'($urandom_range(0, 3) * 1024 + $urandom_range(0, 3) * 16 + $urandom_range(0, 7) * 2);
      access(we, a, 16'($urandom));
    end

    repeat (10) @(negedge clk);
    check("mem_expected_drained", 32'(exp_mem.size()), 32'd0);
    check("rdata_expected_drained", 32'(exp_rd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: byte address width.
REQ-002 Parameter DATA_W, default 16: word width; one word = 2 bytes, addr[0] ignored.
REQ-003 Parameter BLK_WORDS, default 8: words per block, power of 2, >=2.
REQ-004 Parameter NUM_SETS, default 64: sets, direct-mapped, power of 2.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cpu_req  in  1  access request, held until cpu_stall low.
REQ-008 cpu_we  in  1  1=write, 0=read.
REQ-009 cpu_addr  in  ADDR_W  byte address.
REQ-010 cpu_wdata  in  DATA_W  write data.
REQ-011 cpu_rdata  out  DATA_W  read data, valid when cpu_req & ~cpu_we & ~cpu_stall.
REQ-012 cpu_stall  out  1  pipeline hold; freezes PC and IF/ID.
REQ-013 mem_en  out  1  memory request, one per cycle, fire-and-forget.
REQ-014 mem_we  out  1  memory write qualifier.
REQ-015 mem_addr  out  ADDR_W  memory byte address.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_rdata  in  DATA_W  returned read word.
REQ-018 mem_valid  in  1  read word returned (in request order), or write acknowledged.
REQ-019 hit_cnt, miss_cnt  out  16 each  performance counters.

Function
REQ-020 Address split: offset = addr[log2(BLK_WORDS):1], index = next log2(NUM_SETS) bits, tag = remaining upper bits.
REQ-021 Storage: per set one valid bit, tag, BLK_WORDS data words; policy write-through, no-write-allocate.
REQ-022 FSM states IDLE, FILL, WRITE; reset state IDLE.
REQ-023 IDLE, cpu_req low: cpu_stall=0, mem_en=0, no state change.
REQ-024 IDLE read hit (valid & tag match): cpu_rdata combinational same cycle, cpu_stall=0, hit_cnt+1.
REQ-025 IDLE read miss: cpu_stall=1 same cycle, miss_cnt+1, latch block base address, go FILL.
REQ-026 FILL: issue mem_en=1, mem_we=0, mem_addr=base+2k for k=0..BLK_WORDS-1 on consecutive cycles (issue counter); cpu_stall=1 throughout.
REQ-027 FILL: each mem_valid writes mem_rdata into word r of the set (return counter r, 0..BLK_WORDS-1); mem_valid with r out of range ignored.
REQ-028 FILL: on the cycle return r=BLK_WORDS-1 is written, set valid, write tag, go IDLE; the held request hits next cycle (counted as hit).
REQ-029 Valid bit of the filling set cleared on FILL entry; partially filled block never hits.
REQ-030 IDLE write (hit or miss): cpu_stall=1, go WRITE; miss_cnt/hit_cnt updated by hit status.
REQ-031 WRITE: first cycle mem_en=1, mem_we=1, mem_addr=cpu_addr with addr[0]=0, mem_wdata=cpu_wdata; later cycles mem_en=0; stall until mem_valid.
REQ-032 WRITE: on mem_valid, if hit update cached word, cpu_stall=0 that cycle, go IDLE; miss leaves cache unchanged.
REQ-033 mem_valid in IDLE ignored.
REQ-034 Counters saturate at 16'hFFFF; each access counted exactly once.
REQ-035 cpu_addr/cpu_we changes while stalled are a protocol violation; behaviour undefined.

Reset
REQ-036 rst in any state, including mid-FILL/WRITE: next state IDLE, all valid bits 0, issue/return counters 0, hit_cnt=miss_cnt=0, cpu_stall=0, mem_en=0, mem_we=0; tag/data arrays need not be cleared.
REQ-037 After reset, mem_valid responses from aborted requests ignored in IDLE.

Verification (defaults; memory model: read latency 4, word at addr A = A^16'hA5A5, write ack latency 4)
REQ-038 Post-reset read 0x0010 -> stall, 8 mem reads 0x0010..0x001E, stall drops after 8th return, cpu_rdata=0xA5B5, miss_cnt=1, hit_cnt=1.
REQ-039 Then read 0x001E -> no stall, cpu_rdata=0xA5BB, no mem_en, hit_cnt=2.
REQ-040 Then read 0x0410 (same index 1, new tag) -> miss and refill, cpu_rdata=0xA1B5; read 0x0010 again -> miss.
REQ-041 Write 0x0014=0x1234 on resident block -> one mem_en&mem_we at 0x0014, stall until ack, then read 0x0014 -> 0x1234, no mem traffic.
REQ-042 Write miss 0x2000=0xBEEF -> memory write only; subsequent read 0x2000 misses (no allocation).
REQ-043 rst during FILL after 3rd return -> stall 0 next cycle, counters 0, late mem_valids ignored, read of same address misses and refills.
